// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage ALU with multiply/divide:
// operation codes, FSM state encoding and an operation classifier.
package mdu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_NONE  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mduState_t;

  function automatic logic isMduOp(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_alu_if.sv
// Operand, control and result bundle between the EX-stage control and mdu_alu.
// start is sampled only while busy is low; done pulses for one cycle when HI/LO take a result.
interface mdu_alu_if import mdu_pkg::*; #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       aluOp;
  logic             start;
  logic             hiWe;
  logic             loWe;
  logic [WIDTH-1:0] aluResult;
  logic             equalAlu;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  mduState_t        state;

  modport master (
    output srcA, srcB, aluOp, start, hiWe, loWe,
    input  aluResult, equalAlu, busy, done, hi, lo, state
  );

  modport slave (
    input  srcA, srcB, aluOp, start, hiWe, loWe,
    output aluResult, equalAlu, busy, done, hi, lo, state
  );

endinterface

// File: rtl/mdu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per step.
// The load edge performs the first step, so WIDTH-1 further enabled edges complete it.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0]   remReg, quoReg, dvsReg;
  logic [2*WIDTH-1:0] loadStep, runStep;

  // Returns {nextRemainder, nextQuotient}; the quotient register doubles as the dividend shifter.
  function automatic logic [2*WIDTH-1:0] divStep(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh, diff;
    sh   = {r, q[WIDTH-1]};
    diff = sh - {1'b0, d};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else              return {sh[WIDTH-1:0],   q[WIDTH-2:0], 1'b0};
  endfunction

  assign loadStep = divStep('0, dividend, divisor);
  assign runStep  = divStep(remReg, quoReg, dvsReg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remReg <= '0;
      quoReg <= '0;
      dvsReg <= '0;
    end else if (load) begin
      {remReg, quoReg} <= loadStep;
      dvsReg           <= divisor;
    end else if (en) begin
      {remReg, quoReg} <= runStep;
    end
  end

  assign quotient  = quoReg;
  assign remainder = remReg;

endmodule

// File: rtl/mdu_alu.sv
// EX-stage ALU: single-cycle integer ops plus a multi-cycle multiply/divide
// unit that owns the HI/LO registers and reports busy/done to pipeline control.
module mdu_alu import mdu_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input logic     clk,
  input logic     reset,
  mdu_alu_if.slave bus
);

  localparam int DIV_CYCLES = WIDTH;
  localparam int SH_W       = $clog2(WIDTH);
  localparam int MAX_CYC    = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  mduState_t          state, nextState;
  logic [CNT_W-1:0]   cnt;
  logic               launch, lastCycle, busy, doneReg;
  logic [WIDTH-1:0]   hiReg, loReg, aluRes;
  logic [SH_W-1:0]    shamt;
  logic               signedMul, signedDiv;
  logic [2*WIDTH-1:0] extA, extB, product, prodReg;
  logic [WIDTH-1:0]   absA, absB, dividendReg, uQuo, uRem;
  logic               negQ, negR, divZero;

  assign shamt = bus.srcA[SH_W-1:0];

  always_comb begin
    aluRes = '0;
    case (bus.aluOp)
      OP_ADD:  aluRes = bus.srcA + bus.srcB;
      OP_SUB:  aluRes = bus.srcA - bus.srcB;
      OP_AND:  aluRes = bus.srcA & bus.srcB;
      OP_OR:   aluRes = bus.srcA | bus.srcB;
      OP_XOR:  aluRes = bus.srcA ^ bus.srcB;
      OP_NOR:  aluRes = ~(bus.srcA | bus.srcB);
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (bus.srcA < bus.srcB)};
      OP_SLL:  aluRes = bus.srcB << shamt;
      OP_SRL:  aluRes = bus.srcB >> shamt;
      OP_SRA:  aluRes = $unsigned($signed(bus.srcB) >>> shamt);
      default: aluRes = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    launch    = 1'b0;
    lastCycle = 1'b0;
    case (state)
      S_IDLE: if (bus.start && isMduOp(bus.aluOp)) begin
        launch    = 1'b1;
        nextState = (bus.aluOp == OP_MULT || bus.aluOp == OP_MULTU) ? S_MUL : S_DIV;
      end
      S_MUL: if (cnt == MUL_LAST) begin
        lastCycle = 1'b1;
        nextState = S_IDLE;
      end
      S_DIV: if (cnt == DIV_LAST) begin
        lastCycle = 1'b1;
        nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // The low 2*WIDTH bits of the extended product are correct for both signed and unsigned.
  assign signedMul = (bus.aluOp == OP_MULT);
  assign signedDiv = (bus.aluOp == OP_DIV);
  assign extA      = {{WIDTH{signedMul & bus.srcA[WIDTH-1]}}, bus.srcA};
  assign extB      = {{WIDTH{signedMul & bus.srcB[WIDTH-1]}}, bus.srcB};
  assign product   = extA * extB;
  assign absA      = (signedDiv && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
  assign absB      = (signedDiv && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (launch),
    .en        (state == S_DIV),
    .dividend  (absA),
    .divisor   (absB),
    .quotient  (uQuo),
    .remainder (uRem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      doneReg     <= 1'b0;
      hiReg       <= '0;
      loReg       <= '0;
      prodReg     <= '0;
      dividendReg <= '0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      divZero     <= 1'b0;
    end else begin
      doneReg <= lastCycle;
      if (launch)    cnt <= '0;
      else if (busy) cnt <= cnt + 1'b1;
      if (launch) begin
        prodReg     <= product;
        dividendReg <= bus.srcA;
        negQ        <= signedDiv && (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
        negR        <= signedDiv && bus.srcA[WIDTH-1];
        divZero     <= (bus.srcB == '0);
      end
      // mthi/mtlo land even on a launching edge; the finished op overwrites them later.
      if (lastCycle) begin
        if (state == S_MUL) begin
          {hiReg, loReg} <= prodReg;
        end else if (divZero) begin
          loReg <= '1;
          hiReg <= dividendReg;
        end else begin
          loReg <= negQ ? -uQuo : uQuo;
          hiReg <= negR ? -uRem : uRem;
        end
      end else if (!busy) begin
        if (bus.hiWe) hiReg <= bus.srcA;
        if (bus.loWe) loReg <= bus.srcA;
      end
    end
  end

  assign bus.aluResult = aluRes;
  assign bus.equalAlu  = (bus.srcA == bus.srcB);
  assign bus.busy      = busy;
  assign bus.done      = doneReg;
  assign bus.hi        = hiReg;
  assign bus.lo        = loReg;
  assign bus.state     = state;

endmodule

// File: tb/tb_mdu_alu.sv
// Directed self-checking bench for mdu_alu at WIDTH=32, MUL_CYCLES=5.
module tb_mdu_alu;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   nChecks;
  int   nPass;
  int   cyc;

  mdu_alu_if #(.WIDTH(32)) bus ();

  mdu_alu #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic comb(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    bus.aluOp = op;
    bus.srcA  = a;
    bus.srcB  = b;
    #1;
    check(tag, bus.aluResult, exp);
  endtask

  task automatic waitIdle(input int startCnt, output int cycles);
    cycles = startCnt;
    while (bus.busy === 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  // Launch, scramble operands while busy, then wait for completion.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    bus.aluOp = op;
    bus.srcA  = a;
    bus.srcB  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.aluOp = OP_ADD;
    bus.srcA  = 32'hA5A5_A5A5;
    bus.srcB  = 32'h5A5A_5A5A;
    waitIdle(0, cycles);
  endtask

  task automatic checkResult(input string tag, input int cycles, input int expCycles,
                             input logic [31:0] expHi, input logic [31:0] expLo);
    check({tag, "_cycles"}, 32'(cycles), 32'(expCycles));
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_hi"}, bus.hi, expHi);
    check({tag, "_lo"}, bus.lo, expLo);
    tick();
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    nChecks   = 0;
    nPass     = 0;
    reset     = 1'b1;
    bus.srcA  = '0;
    bus.srcB  = '0;
    bus.aluOp = OP_NONE;
    bus.start = 1'b0;
    bus.hiWe  = 1'b0;
    bus.loWe  = 1'b0;
    tick();
    tick();
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_state", 32'(bus.state), 32'(S_IDLE));
    reset = 1'b0;
    tick();

    comb("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    comb("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    comb("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    comb("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    comb("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    comb("nor", OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
    comb("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    comb("slt_no", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0);
    comb("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1);
    comb("sll", OP_SLL, 32'd4, 32'd1, 32'h0000_0010);
    comb("srl", OP_SRL, 32'd4, 32'h8000_0000, 32'h0800_0000);
    comb("sra", OP_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000);
    comb("srl_amt_mask", OP_SRL, 32'h24, 32'h8000_0000, 32'h0800_0000);
    comb("mult_comb_zero", OP_MULT, 32'd3, 32'd5, 32'd0);
    comb("none_zero", OP_NONE, 32'd3, 32'd5, 32'd0);
    check("equal_no", 32'(bus.equalAlu), 32'd0);
    bus.srcB = 32'd3;
    #1;
    check("equal_yes", 32'(bus.equalAlu), 32'd1);

    runOp(OP_MULT, 32'hFFFF_FFFD, 32'd5, cyc);
    checkResult("mult_neg", cyc, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
    checkResult("div_7_m2", cyc, 32, 32'd1, 32'hFFFF_FFFD);
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    checkResult("div_m7_2", cyc, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp(OP_DIVU, 32'd7, 32'd0, cyc);
    checkResult("divu_zero", cyc, 32, 32'd7, 32'hFFFF_FFFF);
    runOp(OP_DIV, 32'hFFFF_FFFB, 32'd0, cyc);
    checkResult("div_zero", cyc, 32, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checkResult("div_min", cyc, 32, 32'd0, 32'h8000_0000);
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    checkResult("multu_max", cyc, 5, 32'hFFFF_FFFE, 32'd1);

    // Relaunch attempt and mthi while busy must not disturb the running multiply.
    bus.aluOp = OP_MULT;
    bus.srcA  = 32'd6;
    bus.srcB  = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.aluOp = OP_DIV;
    bus.srcA  = 32'd100;
    bus.srcB  = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.hiWe  = 1'b1;
    bus.srcA  = 32'h0000_DEAD;
    tick();
    bus.hiWe  = 1'b0;
    check("mthi_busy_hi", bus.hi, 32'hFFFF_FFFE);
    waitIdle(3, cyc);
    checkResult("mult_ignore", cyc, 5, 32'd0, 32'd42);
    check("no_relaunch", 32'(bus.busy), 32'd0);

    bus.hiWe = 1'b1;
    bus.srcA = 32'h1234_5678;
    tick();
    bus.hiWe = 1'b0;
    check("mthi", bus.hi, 32'h1234_5678);
    bus.loWe = 1'b1;
    bus.srcA = 32'hCAFE_F00D;
    tick();
    bus.loWe = 1'b0;
    check("mtlo", bus.lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", bus.hi, 32'h1234_5678);

    bus.hiWe  = 1'b1;
    bus.aluOp = OP_MULT;
    bus.srcA  = 32'd2;
    bus.srcB  = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.hiWe  = 1'b0;
    bus.start = 1'b0;
    check("mthi_launch_hi", bus.hi, 32'd2);
    check("mthi_launch_busy", 32'(bus.busy), 32'd1);
    waitIdle(0, cyc);
    checkResult("mthi_launch", cyc, 5, 32'd0, 32'd6);

    bus.hiWe = 1'b1;
    bus.srcA = 32'h55;
    tick();
    bus.hiWe  = 1'b0;
    bus.aluOp = OP_DIVU;
    bus.srcA  = 32'd100;
    bus.srcB  = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_div_state", 32'(bus.state), 32'(S_DIV));
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    runOp(OP_DIVU, 32'd100, 32'd7, cyc);
    checkResult("divu_after_rst", cyc, 32, 32'd2, 32'd14);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
